// File: rtl/rfifo_fwft_if.sv
// Read-side stream interface for rfifo_fwft: FIFO read port (rempty/rdata/rinc)
// plus the first-word-fall-through valid/ready output stream.
interface rfifo_fwft_if #(
    parameter int DATA_SIZE = 8
);
    logic                 rempty;
    logic [DATA_SIZE-1:0] rdata;
    logic                 rinc;
    logic [DATA_SIZE-1:0] rdout;
    logic                 rvalid;
    logic                 rready;

    modport master (
        input  rempty,
        input  rdata,
        input  rready,
        output rinc,
        output rdout,
        output rvalid
    );

    modport slave (
        output rempty,
        output rdata,
        output rready,
        input  rinc,
        input  rdout,
        input  rvalid
    );
endinterface

// File: rtl/rfifo_fwft.sv
// Async FIFO read-domain output stage: 2-entry (head + skid) FWFT buffer.
// Optional saturating stall counter enabled by macro RFIFO_STALL_CNT_EN.
module rfifo_fwft #(
    parameter int DATA_SIZE   = 8,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   rclk,
    input  logic                   rrst_n,
    rfifo_fwft_if.master           rif
`ifdef RFIFO_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] rstall_cnt
`endif
);

    typedef enum logic [1:0] {
        OCC0 = 2'd0,
        OCC1 = 2'd1,
        OCC2 = 2'd2
    } occ_e;

    occ_e                 occ_q, occ_d;
    logic                 rvalid_q, rvalid_d;
    logic [DATA_SIZE-1:0] head_q, head_d;
    logic [DATA_SIZE-1:0] skid_q, skid_d;
    logic                 push;
    logic                 pop;

    // The read request only looks at registered state, so rready never reaches rinc.
    assign push       = rrst_n && !rif.rempty && (occ_q != OCC2);
    assign pop        = rvalid_q && rif.rready;
    assign rif.rinc   = push;
    assign rif.rdout  = head_q;
    assign rif.rvalid = rvalid_q;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        skid_d = skid_q;
        case (occ_q)
            OCC0: begin
                if (push) begin
                    head_d = rif.rdata;
                    occ_d  = OCC1;
                end
            end
            OCC1: begin
                if (push && !pop) begin
                    skid_d = rif.rdata;
                    occ_d  = OCC2;
                end else if (push && pop) begin
                    head_d = rif.rdata;
                end else if (pop) begin
                    occ_d  = OCC0;
                end
            end
            OCC2: begin
                if (pop) begin
                    head_d = skid_q;
                    occ_d  = OCC1;
                end
            end
            default: begin
                occ_d = OCC0;
            end
        endcase
        rvalid_d = (occ_d != OCC0);
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            occ_q    <= OCC0;
            rvalid_q <= 1'b0;
            head_q   <= '0;
            skid_q   <= '0;
        end else begin
            occ_q    <= occ_d;
            rvalid_q <= rvalid_d;
            head_q   <= head_d;
            skid_q   <= skid_d;
        end
    end

`ifdef RFIFO_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Counts cycles where a word is offered but refused; sticks at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (rvalid_q && !rif.rready && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign rstall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/rfifo_fwft.md
Name: rfifo_fwft

Overview:
- Read-domain output stage of the async FIFO. Sits directly downstream of the read-pointer/empty logic and the FIFO memory.
- Turns the FIFO's rinc/rempty/rdata read port into a first-word-fall-through valid/ready stream.
- A 2-entry output buffer (head + skid) gives full throughput. There is no combinational path from rready to rinc.

Parameters:
- DATA_SIZE, 8, width of FIFO read data and output stream data.
- STALL_CNT_W, 16, width of optional stall counter (used only with RFIFO_STALL_CNT_EN).

Ports:
- rclk  input  1  read-domain clock; all state updates on posedge.
- rrst_n  input  1  asynchronous active-low reset; same net that resets the read pointer logic.
- rempty  input  1  registered empty flag from the read-pointer/empty block.
- rdata  input  DATA_SIZE  FIFO memory read data at current raddr; combinational read, valid in the same cycle.
- rinc  output  1  read-increment request to the read-pointer/empty block.
- rdout  output  DATA_SIZE  stream data; equals head register.
- rvalid  output  1  stream valid; registered.
- rready  input  1  downstream accept.
- rstall_cnt  output  STALL_CNT_W  present only with RFIFO_STALL_CNT_EN.

Behaviour:
- Clocking/reset: single clock rclk. Reset is asynchronous, active-low on rrst_n.
- Reset values: occ=0, rvalid=0, rdout=0, skid=0, rstall_cnt=0. rinc=0 during reset because occ=0 alone does not gate it; rinc is forced 0 while rrst_n=0.
- State: occ ∈ {0,1,2}, registered, 2 bits; value 3 is illegal and must never be reached. Data registers: head, skid.
- rinc = !rempty && (occ != 2). Combinational from registered signals only; must not depend on rready.
- push = rinc. pop = rvalid && rready. rvalid = (occ != 0), driven from a register, not decoded combinationally from rready.
- Transitions:
  - occ0 & push: head<=rdata, occ->1.
  - occ1 & push & !pop: skid<=rdata, occ->2.
  - occ1 & push & pop: head<=rdata, occ->1.
  - occ1 & !push & pop: occ->0; head holds its value.
  - occ2 & pop: head<=skid, occ->1. Push is impossible at occ2.
  - No push and no pop: all state holds.
- Latency: rempty falls at cycle N -> rinc=1 in cycle N -> rvalid=1 and rdout=first word at cycle N+1.
- Throughput: with rready held 1 and the FIFO non-empty, one word per rclk cycle in steady state (occ stays 1).
- Ordering: strict FIFO order. The skid word is always younger than the head word.
- Backpressure: with rready=0, at most 2 words are pulled from the FIFO, then rinc drops. Nothing is read from memory while occ=2.
- rdout/rvalid hold stable while rvalid=1 && rready=0 (AXI-style rule). rdout is don't-care when rvalid=0 but must not glitch to X after reset.
- rempty rising: rinc drops the same cycle. Buffered words remain valid and drain normally.
- rempty toggling during drain: no words are lost or duplicated.
- Reset mid-operation: buffered words are discarded. rvalid goes 0 asynchronously. The first valid word after reset is the FIFO's post-reset content.

Optional Feature:
- Macro RFIFO_STALL_CNT_EN.
- Defined: port rstall_cnt exists. It increments by 1 each cycle with rvalid=1 && rready=0, saturates at all-ones, and holds otherwise. It clears only on rrst_n.
- Undefined: port and counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset: assert rrst_n=0 with rempty=0, rready=1 -> rvalid=0, rdout=0, rinc=0 throughout reset. First rinc appears in the first cycle after release.
- Single word: rempty 1->0 for one read with rdata=8'hA5, rready=1 -> rinc one cycle (N), rvalid=1 with rdout=8'hA5 at N+1, rvalid=0 at N+2.
- Streaming: 16 words 0x00..0x0F, rempty=0 throughout, rready=1 -> rvalid high 16 consecutive cycles, rdout sequence 0x00..0x0F, occ never reaches 2.
- Backpressure: FIFO holds 0x10..0x13, rready=0 -> exactly 2 rinc pulses, rinc=0 thereafter, rdout=0x10 stable. Then rready=1 -> output 0x10,0x11,0x12,0x13 back-to-back, no gaps or duplicates.
- Reset mid-stream: occ=2 holding 0x20,0x21, pulse rrst_n low -> rvalid=0 immediately, and neither 0x20 nor 0x21 appears after release.
- RFIFO_STALL_CNT_EN with STALL_CNT_W=4: hold rvalid=1, rready=0 for 20 cycles -> rstall_cnt reaches 15 and stays 15. Then rready=1 -> counter holds 15.
